// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: synchronises request lines, latches rising edges as
// sticky pending bits, masks them for the priority encoder and drives a held-off irq.
module irq_pending_ctrl #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               HOLDOFF     = 4,
    parameter logic [WIDTH-1:0] MASK_RESET  = {WIDTH{1'b1}},
    localparam int              ID_W        = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_req_in,
    input  logic             i_mask_wr,
    input  logic [WIDTH-1:0] i_mask_in,
    input  logic             i_ack,
    input  logic [ID_W-1:0]  i_ack_id,
    input  logic             i_lost_clr,
    output logic [WIDTH-1:0] o_pending_out,
    output logic             o_irq,
    output logic [WIDTH-1:0] o_mask_q,
    output logic [WIDTH-1:0] o_lost
);

    localparam int         CNT_W     = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int         HOLD_LOAD = (HOLDOFF > 0) ? (HOLDOFF - 1) : 0;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ASSERT  = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_lost;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_pending_out;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_sync_out    = r_sync[SYNC_STAGES-1];
    assign w_edge        = w_sync_out & ~r_prev;
    assign w_pending_out = r_pending & r_mask;

    // Per-bit acknowledge decode; out-of-range ids simply match nothing
    always_comb begin
        w_clr = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_clr[i] = i_ack && (i_ack_id == ID_W'(i));
        end
    end

    // Synchroniser chain and previous-value register for edge detection
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= {WIDTH{1'b0}};
            end
            r_prev <= {WIDTH{1'b0}};
        end else begin
            r_sync[0] <= i_req_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= w_sync_out;
        end
    end

    // Pending, lost and mask registers; a new edge beats a same-cycle clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pending <= {WIDTH{1'b0}};
            r_lost    <= {WIDTH{1'b0}};
            r_mask    <= MASK_RESET;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
            r_lost    <= (i_lost_clr ? {WIDTH{1'b0}} : r_lost) | (w_edge & r_pending & ~w_clr);
            if (i_mask_wr) begin
                r_mask <= i_mask_in;
            end else begin
                r_mask <= r_mask;
            end
        end
    end

    // irq state machine: assert on any enabled pending bit, hold off after an ack
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|w_pending_out) begin
                    w_state_nxt = S_ASSERT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ASSERT: begin
                if (i_ack) begin
                    if (HOLDOFF == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = CNT_W'(HOLD_LOAD);
                    end
                end else if (!(|w_pending_out)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ASSERT;
                end
            end
            S_HOLD: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, hold-off counter and registered irq
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_irq   <= (w_state_nxt == S_ASSERT);
        end
    end

    assign o_pending_out = w_pending_out;
    assign o_irq         = r_irq;
    assign o_mask_q      = r_mask;
    assign o_lost        = r_lost;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: a delay-line reference model predicts every
// cycle's outputs into a queue, a monitor pops and compares after each rising edge.
module tb_irq_pending_ctrl;

    localparam int HOLDOFF = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] req_in = 8'h00;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_in = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] ack_id = 3'd0;
    logic       lost_clr = 1'b0;
    logic [7:0] pending_out;
    logic       irq;
    logic [7:0] mask_q;
    logic [7:0] lost;

    irq_pending_ctrl dut (
        .clock        (clock),
        .resetn       (resetn),
        .i_req_in     (req_in),
        .i_mask_wr    (mask_wr),
        .i_mask_in    (mask_in),
        .i_ack        (ack),
        .i_ack_id     (ack_id),
        .i_lost_clr   (lost_clr),
        .o_pending_out(pending_out),
        .o_irq        (irq),
        .o_mask_q     (mask_q),
        .o_lost       (lost)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] pend;
        logic       irq;
        logic [7:0] mask;
        logic [7:0] lost;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state: mode 0 quiet-idle, 1 irq raised, 2 hold-off
    bit [7:0] m_pend, m_mask, m_lost, m_prev;
    bit [7:0] m_hist[$];
    int       m_mode, m_quiet;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 8'h00; m_mask = 8'hFF; m_lost = 8'h00; m_prev = 8'h00;
        m_mode = 0; m_quiet = 0;
        m_hist.delete();
        m_hist.push_back(8'h00);
        m_hist.push_back(8'h00);
    endtask

    function automatic logic [2:0] msb_of(input bit [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // one clock edge of the behavioural model, expected result queued
    task automatic model_step();
        bit [7:0] seen, rise, old_out;
        exp_t e;
        seen = m_hist[0];
        rise = seen & ~m_prev;
        m_prev = seen;
        void'(m_hist.pop_front());
        m_hist.push_back(req_in);
        old_out = m_pend & m_mask;
        for (int i = 0; i < 8; i++) begin
            bit hit;
            hit = ack && (ack_id == 3'(i));
            if (rise[i] && m_pend[i] && !hit) m_lost[i] = 1'b1;
            else if (lost_clr) m_lost[i] = 1'b0;
            m_pend[i] = rise[i] | (m_pend[i] & !hit);
        end
        case (m_mode)
            0: if (old_out != 8'h00) m_mode = 1;
            1: begin
                if (ack) begin
                    m_mode = (HOLDOFF == 0) ? 0 : 2;
                    m_quiet = HOLDOFF;
                end else if (old_out == 8'h00) m_mode = 0;
            end
            default: begin
                m_quiet--;
                if (m_quiet == 0) m_mode = 0;
            end
        endcase
        if (mask_wr) m_mask = mask_in;
        e.pend = m_pend & m_mask;
        e.irq  = (m_mode == 1);
        e.mask = m_mask;
        e.lost = m_lost;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [7:0] r, input logic mw = 1'b0, input logic [7:0] mi = 8'h00,
                         input logic a = 1'b0, input logic [2:0] aid = 3'd0, input logic lc = 1'b0);
        @(negedge clock);
        req_in = r; mask_wr = mw; mask_in = mi; ack = a; ack_id = aid; lost_clr = lc;
        @(posedge clock);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        req_in = 8'h00; mask_wr = 1'b0; mask_in = 8'h00; ack = 1'b0; ack_id = 3'd0; lost_clr = 1'b0;
        #2;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_pending", 32'(pending_out), 32'h0);
        check("rst_mask", 32'(mask_q), 32'hFF);
        check("rst_lost", 32'(lost), 32'h0);
        model_reset();
        exp_q.delete();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // monitor: compares every registered update against the queued prediction
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_pending", 32'(pending_out), 32'(e.pend));
            check("sb_irq", 32'(irq), 32'(e.irq));
            check("sb_mask", 32'(mask_q), 32'(e.mask));
            check("sb_lost", 32'(lost), 32'(e.lost));
        end
    end

    initial begin
        logic [7:0] rq;
        model_reset();
        do_reset();

        // single request, ack, hold-off with nothing left pending
        repeat (3) cycle(8'h20);
        #2 check("t2_pend", 32'(pending_out), 32'h20);
        check("t2_irq_early", 32'(irq), 32'h0);
        cycle(8'h20);
        #2 check("t2_irq", 32'(irq), 32'h1);
        cycle(8'h20, 1'b0, 8'h00, 1'b1, 3'd5);
        #2 check("t2_ack_pend", 32'(pending_out), 32'h0);
        check("t2_ack_irq", 32'(irq), 32'h0);
        repeat (6) cycle(8'h20);
        #2 check("t2_stays_low", 32'(irq), 32'h0);

        // two requests: ack the top one, the other reasserts after hold-off
        do_reset();
        repeat (4) cycle(8'h81);
        #2 check("t3_pend", 32'(pending_out), 32'h81);
        cycle(8'h81, 1'b0, 8'h00, 1'b1, 3'd7);
        #2 check("t3_ack_pend", 32'(pending_out), 32'h01);
        repeat (4) cycle(8'h81);
        #2 check("t3_holdoff_low", 32'(irq), 32'h0);
        cycle(8'h81);
        #2 check("t3_reassert", 32'(irq), 32'h1);

        // masked bit latches but does not interrupt until unmasked
        do_reset();
        cycle(8'h00, 1'b1, 8'hFE);
        repeat (3) cycle(8'h01);
        #2 check("t4_masked_pend", 32'(pending_out), 32'h0);
        check("t4_masked_irq", 32'(irq), 32'h0);
        cycle(8'h01, 1'b1, 8'hFF);
        #2 check("t4_unmask_pend", 32'(pending_out), 32'h01);
        cycle(8'h01);
        #2 check("t4_unmask_irq", 32'(irq), 32'h1);

        // lost flag, lost_clr, and set-beats-clear on the same bit
        do_reset();
        repeat (4) cycle(8'h08);
        repeat (3) cycle(8'h00);
        repeat (3) cycle(8'h08);
        #2 check("t5_lost", 32'(lost), 32'h08);
        cycle(8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
        #2 check("t5_lost_clr", 32'(lost), 32'h00);
        repeat (3) cycle(8'h00);
        repeat (2) cycle(8'h08);
        cycle(8'h08, 1'b0, 8'h00, 1'b1, 3'd3);
        #2 check("t5_set_wins", 32'(pending_out), 32'h08);
        check("t5_no_lost", 32'(lost), 32'h00);

        // reset while in hold-off with bits still pending
        do_reset();
        repeat (4) cycle(8'h0C);
        cycle(8'h0C, 1'b0, 8'h00, 1'b1, 3'd7);
        #2 check("t6_hold_pend", 32'(pending_out), 32'h0C);
        do_reset();
        repeat (8) cycle(8'h00);
        #2 check("t6_no_irq", 32'(irq), 32'h0);

        // randomized traffic with an asynchronous reset part way through
        rq = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            logic       a, mw, lc;
            logic [2:0] aid;
            logic [7:0] mi;
            if (n == 700) do_reset();
            for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            mw  = ($urandom_range(15) == 0);
            mi  = 8'($urandom);
            a   = ($urandom_range(3) == 0);
            aid = ($urandom_range(3) != 0) ? msb_of(m_pend & m_mask) : 3'($urandom);
            lc  = ($urandom_range(15) == 0);
            cycle(rq, mw, mi, a, aid, lc);
        end

        repeat (2) @(posedge clock);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
